// File: rtl/vdma_frame_point_ctrl.sv
// vdma_frame_point_ctrl: frame-buffer pointer scheduler for one write and one read VDMA sharing BUF_NUM buffers
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   wr_vs, rd_vs           write/read frame sync levels (frame starts on entry into VS_ACTIVE)
//   wr_point, rd_point     3-bit buffer index for the writer / reader
//   wr_update, rd_update   one-cycle pulse when the respective point moved
//   rd_repeat              one-cycle pulse when a read frame started with no new frame
//   drop_cnt, rep_cnt      saturating dropped / repeated frame counts
// Build option: define VDMA_POINT_STAT_EN to implement drop_cnt/rep_cnt; otherwise they read 0.
module vdma_frame_point_ctrl #(
    parameter int   BUF_NUM   = 3,
    parameter logic VS_ACTIVE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_vs,
    input  logic        rd_vs,
    output logic [2:0]  wr_point,
    output logic [2:0]  rd_point,
    output logic        wr_update,
    output logic        rd_update,
    output logic        rd_repeat,
    output logic [15:0] drop_cnt,
    output logic [15:0] rep_cnt
);
    logic       wr_q, rd_q, wr_edge, rd_edge, rd_take, rdy_vld, found;
    logic [2:0] rdy_idx, rd_n, wr_alloc;
    assign wr_edge = (wr_vs == VS_ACTIVE) && (wr_q != VS_ACTIVE);
    assign rd_edge = (rd_vs == VS_ACTIVE) && (rd_q != VS_ACTIVE);
    // READING and WRITING are explicit registers; READY is rdy_idx when rdy_vld.
    // Every other index is FREE, so the allocator only has to skip the post-read
    // READING buffer and the buffer that is turning READY (the current writer).
    always_comb begin
        rd_take  = rd_edge && rdy_vld;
        rd_n     = rd_take ? rdy_idx : rd_point;
        wr_alloc = wr_point;
        found    = 1'b0;
        for (int i = BUF_NUM - 1; i >= 0; i--)
            if (3'(i) != rd_n && 3'(i) != wr_point) begin
                wr_alloc = 3'(i);
                found    = 1'b1;
            end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= !VS_ACTIVE;
            rd_q      <= !VS_ACTIVE;
            wr_point  <= 3'd0;
            rd_point  <= 3'd1;
            rdy_idx   <= 3'd0;
            rdy_vld   <= 1'b0;
            wr_update <= 1'b0;
            rd_update <= 1'b0;
            rd_repeat <= 1'b0;
        end else begin
            wr_q      <= wr_vs;
            rd_q      <= rd_vs;
            wr_update <= wr_edge;
            rd_update <= rd_take;
            rd_repeat <= rd_edge && !rdy_vld;
            rd_point  <= rd_n;
            if (wr_edge) begin
                wr_point <= wr_alloc;
                rdy_idx  <= wr_point;
                rdy_vld  <= 1'b1;
            end else if (rd_take) begin
                rdy_vld  <= 1'b0;
            end
            assert (!wr_edge || found);
        end
    end
`ifdef VDMA_POINT_STAT_EN
    // A READY frame is lost only if the same-cycle read did not consume it.
    logic drop;
    assign drop = wr_edge && rdy_vld && !rd_take;
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 16'd0;
            rep_cnt  <= 16'd0;
        end else begin
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (rd_edge && !rdy_vld && rep_cnt != 16'hFFFF)
                rep_cnt <= rep_cnt + 16'd1;
        end
    end
`else
    assign drop_cnt = 16'd0;
    assign rep_cnt  = 16'd0;
`endif
endmodule
